// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Brief    : 8N1 UART receive path with a two-flop rx synchroniser, mid-bit
//            sampling, a one-cycle byte strobe and framing-error detection.
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
  parameter int CLOCKS_PER_PULSE = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       rx_busy
);

  localparam logic [15:0] c_half_last = 16'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [15:0] c_bit_last  = 16'(CLOCKS_PER_PULSE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sync1;
  logic        r_sync2;
  logic        w_rx_s;
  logic [15:0] r_clk_cnt;
  logic [15:0] w_clk_cnt_nxt;
  logic [2:0]  r_bit_cnt;
  logic [2:0]  w_bit_cnt_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic [7:0]  r_data_out;
  logic [7:0]  w_data_out_nxt;
  logic        r_data_valid;
  logic        w_data_valid_nxt;
  logic        r_frame_error;
  logic        w_frame_error_nxt;

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_state       <= IDLE;
      r_clk_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_sync1       <= rx;
      r_sync2       <= r_sync1;
      r_state       <= w_state_nxt;
      r_clk_cnt     <= w_clk_cnt_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_shift       <= w_shift_nxt;
      r_data_out    <= w_data_out_nxt;
      r_data_valid  <= w_data_valid_nxt;
      r_frame_error <= w_frame_error_nxt;
    end
  end

  // The bit timer restarts at every sample point so each data bit is
  // sampled exactly one bit period after the previous one.
  always_comb begin
    w_state_nxt       = r_state;
    w_clk_cnt_nxt     = r_clk_cnt + 16'd1;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_shift_nxt       = r_shift;
    w_data_out_nxt    = r_data_out;
    w_data_valid_nxt  = 1'b0;
    w_frame_error_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_clk_cnt_nxt = '0;
        if (!w_rx_s) w_state_nxt = START;
      end
      START: begin
        if (r_clk_cnt == c_half_last) begin
          w_clk_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = w_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_clk_cnt == c_bit_last) begin
          w_clk_cnt_nxt = '0;
          w_shift_nxt   = {w_rx_s, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) w_state_nxt = STOP;
          else                   w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        end
      end
      STOP: begin
        if (r_clk_cnt == c_bit_last) begin
          w_clk_cnt_nxt = '0;
          if (w_rx_s) begin
            w_data_out_nxt   = r_shift;
            w_data_valid_nxt = 1'b1;
            w_state_nxt      = IDLE;
          end else begin
            w_frame_error_nxt = 1'b1;
            w_state_nxt       = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must not be decoded as a stream of 0x00.
        w_clk_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: begin
        w_clk_cnt_nxt = '0;
        w_state_nxt   = IDLE;
      end
    endcase
  end

  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign frame_error = r_frame_error;
  assign rx_busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver
// Brief    : Self-checking bench for uart_receiver (CPP=16 and CPP=4 copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx_a [2];
  logic [7:0] dout [2];
  logic       dv   [2];
  logic       fe   [2];
  logic       bsy  [2];
  int         vectors     = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  uart_receiver #(.CLOCKS_PER_PULSE(16)) u_dut16 (
    .clk(clk), .rstn(rstn), .rx(rx_a[0]), .data_out(dout[0]),
    .data_valid(dv[0]), .frame_error(fe[0]), .rx_busy(bsy[0]));

  uart_receiver #(.CLOCKS_PER_PULSE(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .rx(rx_a[1]), .data_out(dout[1]),
    .data_valid(dv[1]), .frame_error(fe[1]), .rx_busy(bsy[1]));

  // Reference: logic sees rx two edges late; a frame begins when that delayed
  // line is low while idle, and samples fall at HALF + n*CPP edges later.
  for (genvar g = 0; g < 2; g++) begin : g_mdl
    localparam int CPP = (g == 0) ? 16 : 4;
    localparam int H   = CPP / 2;
    logic       s1 = 1'b1;
    logic       s2 = 1'b1;
    int         mode = 0;
    int         cnt  = 0;
    int         k    = 0;
    int         n_fe = 0;
    logic [7:0] acc    = '0;
    logic [7:0] e_data = '0;
    logic       e_v    = 1'b0;
    logic       e_fe   = 1'b0;
    logic       e_busy = 1'b0;
    logic       rs     = 1'b1;
    time        vt_q [$];
    logic [7:0] vd_q [$];

    always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        s1 = 1'b1; s2 = 1'b1; mode = 0; cnt = 0; acc = '0;
        e_data = '0; e_v = 1'b0; e_fe = 1'b0; e_busy = 1'b0;
      end else begin
        rs = s2; s2 = s1; s1 = rx_a[g];
        e_v = 1'b0; e_fe = 1'b0;
        case (mode)
          0: if (!rs) begin mode = 1; cnt = 0; end
          1: begin
            cnt++;
            if (cnt == H) begin
              if (rs) mode = 0;
            end else if (cnt > H && (cnt - H) % CPP == 0) begin
              k = (cnt - H) / CPP - 1;
              if (k < 8) acc[k] = rs;
              else if (rs) begin
                e_v = 1'b1; e_data = acc; mode = 0;
                vt_q.push_back($time); vd_q.push_back(acc);
              end else begin
                e_fe = 1'b1; n_fe++; mode = 2;
              end
            end
          end
          default: if (rs) mode = 0;
        endcase
        e_busy = (mode != 0);
      end
    end
  end

  task automatic cmp(input int g, input logic v, input logic f, input logic b,
                     input logic [7:0] d, input logic ev, input logic ef,
                     input logic eb, input logic [7:0] ed);
    vectors++;
    if (v !== ev || f !== ef || b !== eb || d !== ed) begin
      miscompares++;
      $display("FAIL cycle_cmp inst%0d t=%0t: got valid=%b ferr=%b busy=%b data=%02h, required valid=%b ferr=%b busy=%b data=%02h",
               g, $time, v, f, b, d, ev, ef, eb, ed);
    end
  endtask

  always @(negedge clk) begin
    cmp(0, dv[0], fe[0], bsy[0], dout[0],
        g_mdl[0].e_v, g_mdl[0].e_fe, g_mdl[0].e_busy, g_mdl[0].e_data);
    cmp(1, dv[1], fe[1], bsy[1], dout[1],
        g_mdl[1].e_v, g_mdl[1].e_fe, g_mdl[1].e_busy, g_mdl[1].e_data);
  end

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic drive(input int g, input logic v, input int n);
    rx_a[g] = v;
    repeat (n) @(negedge clk);
  endtask

  // Called just after a negedge; t0 is the time of edge 0 (first capture of the start bit).
  task automatic send(input int g, input logic [7:0] b, input logic stopv, output time t0);
    int cpp;
    cpp = (g == 0) ? 16 : 4;
    t0 = $time + 5;
    drive(g, 1'b0, cpp);
    for (int i = 0; i < 8; i++) drive(g, b[i], cpp);
    drive(g, stopv, cpp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time        t0, t1, t2;
    int         nv, nf, gi, cpp, op;
    logic [7:0] b81;
    b81 = 8'h81;
    rx_a[0] = 1'b1; rx_a[1] = 1'b1;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_dout", dout[0], 0);
    chk("reset_valid", dv[0], 0);
    chk("reset_busy", bsy[0], 0);
    #2 rstn = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, 20);

    // Single byte
    send(0, 8'hA5, 1'b1, t0);
    drive(0, 1'b1, 32);
    chk("a5_count", g_mdl[0].vd_q.size(), 1);
    chk("a5_data", g_mdl[0].vd_q[0], 8'hA5);
    chk("a5_strobe_edge", int'((g_mdl[0].vt_q[0] - t0) / 10), 154);
    chk("a5_dout", dout[0], 8'hA5);
    chk("a5_no_ferr", g_mdl[0].n_fe, 0);

    // Back-to-back, no idle gap
    send(0, 8'h00, 1'b1, t0);
    send(0, 8'hFF, 1'b1, t1);
    send(0, 8'h3C, 1'b1, t2);
    drive(0, 1'b1, 32);
    chk("b2b_count", g_mdl[0].vd_q.size(), 4);
    chk("b2b_d0", g_mdl[0].vd_q[1], 8'h00);
    chk("b2b_d1", g_mdl[0].vd_q[2], 8'hFF);
    chk("b2b_d2", g_mdl[0].vd_q[3], 8'h3C);
    chk("b2b_gap1", int'((g_mdl[0].vt_q[2] - g_mdl[0].vt_q[1]) / 10), 160);
    chk("b2b_gap2", int'((g_mdl[0].vt_q[3] - g_mdl[0].vt_q[2]) / 10), 160);

    // 3-cycle glitch: busy from edge 2 through edge 9, low after edge 10
    nv = g_mdl[0].vd_q.size();
    nf = g_mdl[0].n_fe;
    drive(0, 1'b0, 3);
    chk("glitch_busy_hi", bsy[0], 1);
    drive(0, 1'b1, 7);
    chk("glitch_busy_late", bsy[0], 1);
    drive(0, 1'b1, 1);
    chk("glitch_busy_lo", bsy[0], 0);
    drive(0, 1'b1, 16);
    chk("glitch_no_valid", g_mdl[0].vd_q.size(), nv);
    chk("glitch_no_ferr", g_mdl[0].n_fe, nf);

    // Framing error followed by a long break
    send(0, 8'h55, 1'b0, t0);
    drive(0, 1'b0, 40 * 16);
    chk("brk_busy", bsy[0], 1);
    chk("brk_dout_kept", dout[0], 8'h3C);
    chk("brk_ferr_count", g_mdl[0].n_fe, nf + 1);
    drive(0, 1'b1, 4);
    chk("brk_release_idle", bsy[0], 0);
    drive(0, 1'b1, 32);
    chk("brk_no_valid", g_mdl[0].vd_q.size(), nv);
    chk("brk_ferr_once", g_mdl[0].n_fe, nf + 1);

    // Reset in the middle of data bit 4 of 0x81
    drive(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive(0, b81[i], 16);
    drive(0, b81[4], 8);
    #2 rstn = 1'b0;
    rx_a[0] = 1'b1;
    @(negedge clk);
    chk("rst_mid_dout", dout[0], 0);
    chk("rst_mid_valid", dv[0], 0);
    chk("rst_mid_ferr", fe[0], 0);
    chk("rst_mid_busy", bsy[0], 0);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, 16);
    send(0, 8'h7E, 1'b1, t0);
    drive(0, 1'b1, 32);
    chk("rst_after_count", g_mdl[0].vd_q.size(), nv + 1);
    chk("rst_after_data", g_mdl[0].vd_q[nv], 8'h7E);
    chk("rst_after_dout", dout[0], 8'h7E);

    // Short bit period
    send(1, 8'hC3, 1'b1, t0);
    drive(1, 1'b1, 16);
    chk("cpp4_count", g_mdl[1].vd_q.size(), 1);
    chk("cpp4_data", g_mdl[1].vd_q[0], 8'hC3);
    chk("cpp4_strobe_edge", int'((g_mdl[1].vt_q[0] - t0) / 10), 40);
    chk("cpp4_dout", dout[1], 8'hC3);

    // Randomised traffic: good frames, bad stop bits, short lows, random gaps
    for (int i = 0; i < 48; i++) begin
      gi  = i % 2;
      cpp = (gi == 0) ? 16 : 4;
      op  = int'($urandom_range(0, 9));
      if (op < 7) begin
        send(gi, 8'($urandom), 1'b1, t0);
      end else if (op == 7) begin
        send(gi, 8'($urandom), 1'b0, t0);
        drive(gi, 1'b0, int'($urandom_range(0, 3 * cpp)));
      end else begin
        drive(gi, 1'b0, int'($urandom_range(1, cpp)));
      end
      drive(gi, 1'b1, int'($urandom_range(0, cpp)));
    end
    drive(0, 1'b1, 400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
